sr_latch_arbiter: RTL and testbench

- Shares one NAND-based SR latch (active-low set/reset inputs) among N requesters.
- Round-robin arbitration picks one requester at a time. The block drives a timed set or reset pulse, then a recovery gap, then returns a done handshake.
- Guarantees the latch never sees the forbidden state (both inputs low) and keeps a registered shadow of the latch value.
- Sits between control logic and the latch primitive in the digital-circuits library.

---
 rtl/sr_latch_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_sr_latch_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_arbiter.sv
// sr_latch_arbiter
//   Lets N requesters share one NAND SR latch (active-low S/R inputs).
//   Requests are served in round-robin order. Each transaction is a timed
//   S or R pulse, then a recovery gap with both inputs high, then a
//   one-cycle done handshake.
//   The latch never sees both inputs low. A registered shadow of the
//   expected latch value is kept alongside.
//
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   set_req   [N] per-requester set request (level, held until own done)
//   clr_req   [N] per-requester clear request (level, held until own done)
//   latch_q   latch Q readback (only used with SR_LATCH_ARBITER_QCHK_EN)
//   s_n, r_n  active-low set / reset drive to the latch
//   gnt       [N] one-hot grant, held for the whole transaction
//   done      one-cycle completion pulse, qualified by gnt
//   busy      high whenever the FSM is not idle
//   q_shadow  registered expected latch value
//   err       sticky readback mismatch (SR_LATCH_ARBITER_QCHK_EN only, else 0)
//
// Optional feature macro: SR_LATCH_ARBITER_QCHK_EN
//
// State table
//   IDLE  | waiting for an eligible requester, arbitrating every cycle
//   DRIVE | S or R held low for PULSE_CYCLES
//   GAP   | both inputs high for GAP_CYCLES so the latch settles
//   DONE  | done pulse, shadow already updated, pointer advances
module sr_latch_arbiter #(
  parameter int N            = 4,
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] set_req,
  input  logic [N-1:0] clr_req,
  input  logic         latch_q,
  output logic         s_n,
  output logic         r_n,
  output logic [N-1:0] gnt,
  output logic         done,
  output logic         busy,
  output logic         q_shadow,
  output logic         err
);

  localparam int IW   = (N > 1) ? $clog2(N) : 1;
  localparam int MAXC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] win_q, win_d;
  logic [IW-1:0] rr_q, rr_d;
  logic          op_set_q, op_set_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic          s_n_q, s_n_d;
  logic          r_n_q, r_n_d;
  logic          q_shadow_q, q_shadow_d;

  // Arbitration: first eligible index at or after the round-robin pointer.
  // A requester raising both set and clear is not eligible.
  logic [N-1:0]  eligible;
  logic          found;
  logic [IW-1:0] win_idx;
  logic [IW:0]   arb_sum;
  logic [IW-1:0] arb_idx;

  always_comb begin
    eligible = set_req ^ clr_req;
    found    = 1'b0;
    win_idx  = '0;
    arb_sum  = '0;
    arb_idx  = '0;
    for (int k = 0; k < N; k++) begin
      arb_sum = {1'b0, rr_q} + (IW+1)'(k);
      if (arb_sum >= (IW+1)'(N)) arb_sum = arb_sum - (IW+1)'(N);
      arb_idx = arb_sum[IW-1:0];
      if (!found && eligible[arb_idx]) begin
        found   = 1'b1;
        win_idx = arb_idx;
      end
    end
  end

  // s_n/r_n are registered and computed from the next state, so the drive
  // appears in the cycle right after the request is sampled. The async reset
  // then releases both lines immediately.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    win_d      = win_q;
    rr_d       = rr_q;
    op_set_d   = op_set_q;
    gnt_d      = gnt_q;
    s_n_d      = 1'b1;
    r_n_d      = 1'b1;
    q_shadow_d = q_shadow_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          win_d    = win_idx;
          op_set_d = set_req[win_idx];
          gnt_d    = N'(1) << win_idx;
          cnt_d    = CW'(PULSE_CYCLES);
          s_n_d    = ~set_req[win_idx];
          r_n_d    = set_req[win_idx];
          state_d  = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q == CW'(1)) begin
          cnt_d   = CW'(GAP_CYCLES);
          state_d = GAP;
        end else begin
          cnt_d = cnt_q - CW'(1);
          s_n_d = ~op_set_q;
          r_n_d = op_set_q;
        end
      end
      GAP: begin
        if (cnt_q == CW'(1)) begin
          q_shadow_d = op_set_q;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        gnt_d   = '0;
        rr_d    = (win_q == IW'(N - 1)) ? '0 : win_q + IW'(1);
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      win_q      <= '0;
      rr_q       <= '0;
      op_set_q   <= 1'b0;
      gnt_q      <= '0;
      s_n_q      <= 1'b1;
      r_n_q      <= 1'b1;
      q_shadow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      win_q      <= win_d;
      rr_q       <= rr_d;
      op_set_q   <= op_set_d;
      gnt_q      <= gnt_d;
      s_n_q      <= s_n_d;
      r_n_q      <= r_n_d;
      q_shadow_q <= q_shadow_d;
    end
  end

`ifdef SR_LATCH_ARBITER_QCHK_EN
  logic sync1_q, sync2_q;
  logic err_q, err_d;

  // In DONE q_shadow already holds the new value, so compare it directly.
  always_comb begin
    err_d = err_q;
    if (state_q == DONE && sync2_q != q_shadow_q) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync1_q <= latch_q;
      sync2_q <= sync1_q;
      err_q   <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_latch_q;
  assign unused_latch_q = latch_q;
  assign err            = 1'b0;
`endif

  assign s_n      = s_n_q;
  assign r_n      = r_n_q;
  assign gnt      = gnt_q;
  assign done     = (state_q == DONE);
  assign busy     = (state_q != IDLE);
  assign q_shadow = q_shadow_q;

endmodule

// File: tb/tb_sr_latch_arbiter.sv
module tb_sr_latch_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] set_req = '0;
  logic [3:0] clr_req = '0;
  logic       latch_q = 1'b0;
  logic       s_n, r_n, done, busy, q_shadow, err;
  logic [3:0] gnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sr_latch_arbiter #(.N(4), .PULSE_CYCLES(2), .GAP_CYCLES(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_req  (set_req),
    .clr_req  (clr_req),
    .latch_q  (latch_q),
    .s_n      (s_n),
    .r_n      (r_n),
    .gnt      (gnt),
    .done     (done),
    .busy     (busy),
    .q_shadow (q_shadow),
    .err      (err)
  );

  typedef struct {
    logic [3:0] set_v;
    logic [3:0] clr_v;
    logic [3:0] e_gnt;
    logic       e_s_n;
    logic       e_r_n;
    logic       e_done;
    logic       e_busy;
    logic       e_q;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_req = '0;
    clr_req = '0;
    rst_n   = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic set_vec(input int i, input logic [3:0] s, input logic [3:0] c,
                         input logic [3:0] g, input logic sn, input logic rn,
                         input logic d, input logic b, input logic q);
    vecs[i].set_v  = s;
    vecs[i].clr_v  = c;
    vecs[i].e_gnt  = g;
    vecs[i].e_s_n  = sn;
    vecs[i].e_r_n  = rn;
    vecs[i].e_done = d;
    vecs[i].e_busy = b;
    vecs[i].e_q    = q;
  endtask

  initial begin
    int   gi, rfalls, slow, spin;
    logic prev_r;
    logic [3:0] gprev;
    bit   seen3, got;
    int   gnt2_bad;

    //        set    clr    gnt    s_n r_n done busy q
    set_vec(0,  4'b0001, 4'b0000, 4'b0001, 0, 1, 0, 1, 0);
    set_vec(1,  4'b0001, 4'b0000, 4'b0001, 0, 1, 0, 1, 0);
    set_vec(2,  4'b0001, 4'b0000, 4'b0001, 1, 1, 0, 1, 0);
    set_vec(3,  4'b0001, 4'b0000, 4'b0001, 1, 1, 1, 1, 1);
    set_vec(4,  4'b0000, 4'b0000, 4'b0000, 1, 1, 0, 0, 1);
    set_vec(5,  4'b0000, 4'b0010, 4'b0010, 1, 0, 0, 1, 1);
    set_vec(6,  4'b0000, 4'b0010, 4'b0010, 1, 0, 0, 1, 1);
    set_vec(7,  4'b0000, 4'b0010, 4'b0010, 1, 1, 0, 1, 1);
    set_vec(8,  4'b0000, 4'b0010, 4'b0010, 1, 1, 1, 1, 0);
    set_vec(9,  4'b0000, 4'b0000, 4'b0000, 1, 1, 0, 0, 0);
    set_vec(10, 4'b0101, 4'b0000, 4'b0100, 0, 1, 0, 1, 0);
    set_vec(11, 4'b0101, 4'b0000, 4'b0100, 0, 1, 0, 1, 0);
    set_vec(12, 4'b0101, 4'b0000, 4'b0100, 1, 1, 0, 1, 0);
    set_vec(13, 4'b0101, 4'b0000, 4'b0100, 1, 1, 1, 1, 1);
    set_vec(14, 4'b0001, 4'b0000, 4'b0000, 1, 1, 0, 0, 1);
    set_vec(15, 4'b0001, 4'b0000, 4'b0001, 0, 1, 0, 1, 1);

    // reset values, sampled while reset is held
    rst_n = 1'b0;
    #12;
    chk("rst_s_n", s_n, 1);
    chk("rst_r_n", r_n, 1);
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_q", q_shadow, 0);
    chk("rst_err", err, 0);

    // table: single set, single clear, pointer skip, wrap, redundant set
    do_reset();
    for (int i = 0; i < 16; i++) begin
      set_req = vecs[i].set_v;
      clr_req = vecs[i].clr_v;
      step();
      chk($sformatf("v%0d_gnt", i), gnt, vecs[i].e_gnt);
      chk($sformatf("v%0d_s_n", i), s_n, vecs[i].e_s_n);
      chk($sformatf("v%0d_r_n", i), r_n, vecs[i].e_r_n);
      chk($sformatf("v%0d_done", i), done, vecs[i].e_done);
      chk($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
      chk($sformatf("v%0d_q", i), q_shadow, vecs[i].e_q);
    end

    // all four clear at once: strict order, 5 cycles apart
    do_reset();
    clr_req = 4'b1111;
    gi = 0; rfalls = 0; slow = 0; prev_r = 1'b1; gprev = '0;
    for (int c = 0; c < 25; c++) begin
      step();
      if (!r_n && prev_r) rfalls++;
      prev_r = r_n;
      if (!s_n) slow++;
      if (gnt != 0 && gprev == 0) begin
        chk("rr_order", gnt, 1 << (gi % 4));
        chk("rr_spacing", c, gi * 5);
        gi++;
      end
      if (done) clr_req = clr_req & ~gnt;
      gprev = gnt;
    end
    chk("rr_grants", gi, 4);
    chk("rr_r_pulses", rfalls, 4);
    chk("rr_s_low", slow, 0);

    // requester 2 with both bits high is skipped
    do_reset();
    set_req = 4'b1100;
    clr_req = 4'b0100;
    step();
    chk("both_high_first", gnt, 4'b1000);
    seen3 = 0; gnt2_bad = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (gnt[2]) gnt2_bad++;
      if (done && gnt[3]) begin
        seen3 = 1;
        set_req[3] = 1'b0;
      end
    end
    chk("both_high_req3_done", seen3, 1);
    chk("both_high_never_gnt2", gnt2_bad, 0);
    clr_req[2] = 1'b0;
    got = 0;
    for (int c = 0; c < 5 && !got; c++) begin
      step();
      if (gnt == 4'b0100) got = 1;
    end
    chk("req2_after_drop", got, 1);

    // async reset during DRIVE of a set
    do_reset();
    set_req = 4'b0001;
    step();
    chk("drv_s_n_low", s_n, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_s_n", s_n, 1);
    chk("async_r_n", r_n, 1);
    chk("async_gnt", gnt, 0);
    chk("async_busy", busy, 0);
    chk("async_q", q_shadow, 0);

    // random traffic: safety invariants every cycle
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      set_req = 4'($urandom);
      clr_req = 4'($urandom);
      step();
      chk("inv_forbidden", (!s_n && !r_n), 0);
      chk("inv_onehot", $onehot0(gnt), 1);
      chk("inv_busy", busy, (gnt != 0));
      if (done) chk("inv_done_gnt", (gnt != 0), 1);
    end

    // readback check with latch_q stuck at 0
    do_reset();
    latch_q = 1'b0;
    set_req = 4'b0001;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      step();
      if (done) begin
        got = 1;
        set_req = '0;
      end
    end
    chk("qchk_set_done", got, 1);
    step();
`ifdef SR_LATCH_ARBITER_QCHK_EN
    chk("qchk_err_set", err, 1);
`else
    chk("qchk_err_off", err, 0);
`endif
    set_req = 4'b0010;
    spin = 0;
    got = 0;
    while (!got && spin < 10) begin
      step();
      spin++;
      if (done) begin
        got = 1;
        set_req = '0;
      end
    end
    chk("qchk_second_done", got, 1);
    step();
`ifdef SR_LATCH_ARBITER_QCHK_EN
    chk("qchk_err_sticky", err, 1);
`else
    chk("qchk_err_off2", err, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
